// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the receive path (and the planned transmitter).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_e;

  typedef struct packed {
    logic brk;
    logic par;
    logic frm;
  } rx_err_t;

  localparam int unsigned OVERSAMPLE = 16;

  // Oversample ticks within a bit at which the line is sampled for the vote.
  localparam logic [3:0] VOTE_PH_A = 4'd7;
  localparam logic [3:0] VOTE_PH_B = 4'd8;
  localparam logic [3:0] VOTE_PH_C = 4'd9;

  // Clocks per oversample tick for a given system clock and baud rate.
  function automatic logic [15:0] calc_prescale(input int unsigned clk_hz,
                                                input int unsigned baud);
    return 16'(clk_hz / (baud * OVERSAMPLE));
  endfunction

  // Two-out-of-three majority.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output and extended pointers.
module sync_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     wr_accept,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_rd;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd     = rd_en && !empty;
  // A write into a full FIFO is still taken when the head is leaving this cycle.
  assign wr_accept = wr_en && (!full || do_rd);
  assign level     = wr_ptr - rd_ptr;
  assign rd_data   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; natural modulo wrap on the extra MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are masked by empty so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver: 16x oversampling, majority vote, configurable frame, break
// detection and a receive FIFO carrying per-word error flags.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 72_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned DATA_BITS   = 8,
  parameter parity_e     PARITY      = PAR_NONE,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic [15:0]                   cfg_prescale,
  output logic [DATA_BITS-1:0]          m_tdata,
  output logic [2:0]                    m_tuser,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic                          busy
);

  localparam logic [15:0]  DEF_PRESCALE = calc_prescale(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned  BW           = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);
  localparam logic         HAS_PAR      = (PARITY != PAR_NONE);
  localparam logic         ODD_PAR      = (PARITY == PAR_ODD);

  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_bits
    $error("uart_rx_ext DATA_BITS must be 5..9");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
    $error("uart_rx_ext STOP_BITS must be 1 or 2");
  end

  rx_state_e            state;
  logic                 rx_s1, rx_s2, rx_d;
  logic                 fall;
  logic [15:0]          presc_cfg, presc_q, presc_cur;
  logic [15:0]          tick_cnt;
  logic                 tick;
  logic [3:0]           ph;
  logic                 smp_a, smp_b;
  logic                 vote_en, vote_bit;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_idx;
  logic                 par_bit;
  logic                 stop_idx;
  logic                 last_stop;
  logic                 frm_q;
  logic                 brk_c, par_err_c;
  logic                 push, push_ok, pop;
  rx_err_t              push_err;
  logic [DATA_BITS+2:0] fifo_rd;
  logic                 fifo_empty;

  // Two-flop synchroniser plus edge-detect register, all idling high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign fall = rx_d & ~rx_s2;

  // Effective prescale follows the config only while idle; frozen during a frame.
  assign presc_cfg = (cfg_prescale == 16'd0) ? DEF_PRESCALE : cfg_prescale;
  assign presc_cur = (state == ST_IDLE) ? presc_cfg : presc_q;

  // Latch the prescale every idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= DEF_PRESCALE;
    else if (state == ST_IDLE) presc_q <= presc_cfg;
  end

  assign tick = (tick_cnt == 16'd0);

  // Oversample tick down-counter; restarted at the start edge to align the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= DEF_PRESCALE - 16'd1;
    else if (((state == ST_IDLE) && fall) || tick) tick_cnt <= presc_cur - 16'd1;
    else tick_cnt <= tick_cnt - 16'd1;
  end

  // Phase within the bit and the first two vote samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph    <= '0;
      smp_a <= 1'b1;
      smp_b <= 1'b1;
    end else if (state == ST_IDLE) begin
      ph <= '0;
    end else if (tick) begin
      ph <= ph + 4'd1;
      if (ph == VOTE_PH_A) smp_a <= rx_s2;
      if (ph == VOTE_PH_B) smp_b <= rx_s2;
    end
  end

  assign vote_en  = tick && (ph == VOTE_PH_C) &&
                    (state != ST_IDLE) && (state != ST_BRK_WAIT);
  assign vote_bit = maj3(smp_a, smp_b, rx_s2);

  assign last_stop = ({31'd0, stop_idx} == (STOP_BITS - 1));
  assign par_err_c = HAS_PAR && ((^shreg ^ par_bit ^ ODD_PAR) != 1'b0);
  assign brk_c     = (shreg == '0) && (!HAS_PAR || !par_bit) && !vote_bit && !stop_idx;

  // Frame is pushed at the vote of the last stop bit, or at the first stop bit on a break.
  assign push         = vote_en && (state == ST_STOP) && (brk_c || last_stop);
  assign push_err.brk = brk_c;
  assign push_err.par = par_err_c;
  assign push_err.frm = frm_q | ~vote_bit;

  // Receive FSM; transitions happen at each bit's vote so the next bit is timed seamlessly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      par_bit  <= 1'b0;
      stop_idx <= 1'b0;
      frm_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fall) state <= ST_START;
        end
        ST_START: begin
          if (vote_en) begin
            if (vote_bit) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              bit_idx <= '0;
              par_bit <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (vote_en) begin
            shreg <= {vote_bit, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              state    <= HAS_PAR ? ST_PARITY : ST_STOP;
              stop_idx <= 1'b0;
              frm_q    <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (vote_en) begin
            par_bit <= vote_bit;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (vote_en) begin
            frm_q <= frm_q | ~vote_bit;
            if (brk_c)          state    <= ST_BRK_WAIT;
            else if (last_stop) state    <= ST_IDLE;
            else                stop_idx <= 1'b1;
          end
        end
        ST_BRK_WAIT: begin
          if (rx_s2) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign pop  = m_tvalid && m_tready;

  sync_fifo #(
    .WIDTH (DATA_BITS + 3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (push),
    .wr_data   ({push_err, shreg}),
    .rd_en     (pop),
    .rd_data   (fifo_rd),
    .empty     (fifo_empty),
    .wr_accept (push_ok),
    .level     (fifo_level)
  );

  assign m_tvalid = !fifo_empty;
  assign m_tdata  = fifo_rd[DATA_BITS-1:0];
  assign m_tuser  = fifo_rd[DATA_BITS+2:DATA_BITS];

  // Sticky overrun; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun <= 1'b0;
    else if (push && !push_ok) overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end

endmodule
